// File: rtl/twiddle_fetch_if.sv
// Twiddle fetch bundle: frame control, twiddle ROM read port and butterfly stream.
// The master side is the fetch controller.
interface twiddle_fetch_if #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 28
);
   logic              start;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] tw_data;
   logic              tw_valid;
   logic              tw_ready;
   logic              tw_last;

   modport master (
      input  start, rom_data, tw_ready,
      output busy, done, rom_addr, tw_data, tw_valid, tw_last
   );

   modport slave (
      output start, rom_data, tw_ready,
      input  busy, done, rom_addr, tw_data, tw_valid, tw_last
   );
endinterface

// File: rtl/twiddle_fetch_ctrl.sv
// Twiddle ROM read sequencer for one radix-2 FFT stage: issues per-butterfly
// addresses, absorbs the ROM's 1-cycle latency and streams twiddles out.
module twiddle_fetch_ctrl #(
   parameter int ADDR_W      = 2,
   parameter int DATA_W      = 28,
   parameter int FRAME_LEN   = 8,
   parameter int STRIDE_LOG2 = 0,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   twiddle_fetch_if.master bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [15:0] LAST_B = 16'(FRAME_LEN - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   state_e            state_q, state_d;
   logic [15:0]       b_q, b_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [1:0]        vld_pipe_q, vld_pipe_d;
   logic [1:0]        last_pipe_q, last_pipe_d;
   logic [DATA_W:0]   mem_q [FIFO_DEPTH];
   logic [DATA_W:0]   mem_d [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              done_q, done_d;

   logic [CW:0]       occ;
   logic              issue, is_last_b, push, pop;
   logic [DATA_W:0]   head;

   // Credit covers both the FIFO contents and the addresses still in the ROM pipe.
   assign occ       = {1'b0, count_q} + (CW+1)'(vld_pipe_q[0]) + (CW+1)'(vld_pipe_q[1]);
   assign issue     = (state_q == RUN) && (occ < (CW+1)'(FIFO_DEPTH));
   assign is_last_b = (b_q == LAST_B);
   assign push      = vld_pipe_q[1];
   assign pop       = (count_q != '0) && bus.tw_ready;
   assign head      = mem_q[rd_ptr_q];

   always_comb begin
      state_d     = state_q;
      b_d         = b_q;
      rom_addr_d  = rom_addr_q;
      done_d      = 1'b0;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      vld_pipe_d  = {vld_pipe_q[0], issue};
      last_pipe_d = {last_pipe_q[0], issue && is_last_b};
      count_d     = count_q + CW'(push) - CW'(pop);

      case (state_q)
         IDLE: if (bus.start) begin
            state_d = RUN;
            b_d     = '0;
         end
         RUN: if (issue) begin
            rom_addr_d = ADDR_W'(b_q >> STRIDE_LOG2);
            b_d        = b_q + 16'd1;
            if (is_last_b) state_d = DRAIN;
         end
         DRAIN: if (pop && head[DATA_W]) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (push) begin
         mem_d[wr_ptr_q] = {last_pipe_q[1], bus.rom_data};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         b_q         <= '0;
         rom_addr_q  <= '0;
         vld_pipe_q  <= '0;
         last_pipe_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         b_q         <= b_d;
         rom_addr_q  <= rom_addr_d;
         vld_pipe_q  <= vld_pipe_d;
         last_pipe_q <= last_pipe_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         done_q      <= done_d;
      end
      mem_q <= mem_d;
   end

   // A push into a full FIFO without a matching pop would mean the credit logic is broken.
   always_ff @(posedge clk) begin
      if (rst_n) assert (!(push && !pop && (count_q == CW'(FIFO_DEPTH))));
   end

   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = done_q;
   assign bus.rom_addr = rom_addr_q;
   assign bus.tw_valid = (count_q != '0);
   assign bus.tw_data  = bus.tw_valid ? head[DATA_W-1:0] : '0;
   assign bus.tw_last  = bus.tw_valid & head[DATA_W];
endmodule

// File: tb/tb_twiddle_fetch_ctrl.sv
// Directed bench for twiddle_fetch_ctrl: default frame, stride-2 frame and a
// 64-beat frame under random backpressure, each on its own instance.
module tb_twiddle_fetch_ctrl;
   logic clk;
   logic rst_n;
   int   n_pass  = 0;
   int   n_total = 0;

   logic [27:0] rom_tbl [4] = '{28'h6710886, 28'h4745096, 28'h0004096, 28'h2209902};
   int          sa      [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

   twiddle_fetch_if #(.ADDR_W(2), .DATA_W(28)) b0 ();
   twiddle_fetch_if #(.ADDR_W(2), .DATA_W(28)) b1 ();
   twiddle_fetch_if #(.ADDR_W(2), .DATA_W(28)) b2 ();

   twiddle_fetch_ctrl #(.FRAME_LEN(8))                 dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   twiddle_fetch_ctrl #(.FRAME_LEN(8), .STRIDE_LOG2(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   twiddle_fetch_ctrl #(.FRAME_LEN(64))                dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

   // Free-running registered ROM models
   always @(posedge clk) begin
      b0.rom_data <= rom_tbl[b0.rom_addr];
      b1.rom_data <= rom_tbl[b1.rom_addr];
      b2.rom_data <= rom_tbl[b2.rom_addr];
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      int beats, dones, first_beats, maxcnt, c;
      logic stalled, pl;
      logic [27:0] pd;

      rst_n = 1'b0;
      b0.start = 1'b0; b1.start = 1'b0; b2.start = 1'b0;
      b0.tw_ready = 1'b0; b1.tw_ready = 1'b0; b2.tw_ready = 1'b0;

      // Reset held with start asserted
      b0.start = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", b0.busy, 0);
      chk("rst_valid", b0.tw_valid, 0);
      chk("rst_done", b0.done, 0);
      chk("rst_addr", b0.rom_addr, 0);
      chk("rst_last", b0.tw_last, 0);
      chk("rst_data", b0.tw_data, 0);
      b0.start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_addr", b0.rom_addr, 0);

      // Full throughput, cycle-exact timeline after start edge E0
      b0.tw_ready = 1'b1;
      b0.start = 1'b1;
      @(negedge clk);
      b0.start = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk("ft_addr", b0.rom_addr, (k <= 8) ? (k - 1) % 4 : 3);
         chk("ft_valid", b0.tw_valid, (k >= 3 && k <= 10));
         chk("ft_last", b0.tw_last, (k == 10));
         chk("ft_done", b0.done, (k == 11));
         chk("ft_busy", b0.busy, (k <= 10));
         if (k >= 3 && k <= 10) chk("ft_data", b0.tw_data, rom_tbl[(k - 3) % 4]);
      end

      // Stride 2: each address repeated twice
      b1.tw_ready = 1'b1;
      b1.start = 1'b1;
      @(negedge clk);
      b1.start = 1'b0;
      beats = 0;
      for (c = 0; c < 40 && beats < 8; c++) begin
         @(negedge clk);
         if (b1.tw_valid) begin
            chk("st_data", b1.tw_data, rom_tbl[sa[beats]]);
            chk("st_last", b1.tw_last, (beats == 7));
            beats++;
         end
      end
      chk("st_beats", beats, 8);

      // 64-beat frame with ~30% ready duty
      b2.start = 1'b1;
      @(negedge clk);
      b2.start = 1'b0;
      beats = 0; dones = 0; maxcnt = 0; stalled = 1'b0; pd = '0; pl = 1'b0;
      for (c = 0; c < 3000 && dones == 0; c++) begin
         @(negedge clk);
         if (b2.done) dones++;
         if (int'(dut2.count_q) > maxcnt) maxcnt = int'(dut2.count_q);
         if (stalled) begin
            chk("bp_hold_valid", b2.tw_valid, 1);
            chk("bp_hold_data", b2.tw_data, pd);
            chk("bp_hold_last", b2.tw_last, pl);
         end
         b2.tw_ready = ($urandom_range(0, 9) < 3);
         if (b2.tw_valid && b2.tw_ready) begin
            chk("bp_data", b2.tw_data, rom_tbl[beats % 4]);
            chk("bp_last", b2.tw_last, (beats == 63));
            beats++;
         end
         stalled = b2.tw_valid && !b2.tw_ready;
         pd = b2.tw_data;
         pl = b2.tw_last;
      end
      b2.tw_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (b2.done) dones++;
      end
      chk("bp_beats", beats, 64);
      chk("bp_dones", dones, 1);
      chk("bp_maxcnt_le4", (maxcnt <= 4), 1);

      // Start ignored mid-frame, accepted in the done cycle
      b0.tw_ready = 1'b1;
      b0.start = 1'b1;
      @(negedge clk);
      b0.start = 1'b0;
      beats = 0; dones = 0; first_beats = -1;
      for (c = 1; c < 80 && dones < 2; c++) begin
         @(negedge clk);
         b0.start = 1'b0;
         if (c == 5) b0.start = 1'b1;
         if (b0.tw_valid) begin
            chk("sb_data", b0.tw_data, rom_tbl[beats % 4]);
            chk("sb_last", b0.tw_last, (beats % 8 == 7));
            beats++;
         end
         if (b0.done) begin
            dones++;
            if (dones == 1) begin
               first_beats = beats;
               b0.start = 1'b1;
            end
         end
      end
      b0.start = 1'b0;
      chk("sb_first_beats", first_beats, 8);
      chk("sb_total_beats", beats, 16);
      chk("sb_dones", dones, 2);

      // Reset mid-frame while stalled
      @(negedge clk);
      b0.start = 1'b1;
      @(negedge clk);
      b0.start = 1'b0;
      beats = 0;
      for (c = 0; c < 40 && beats < 3; c++) begin
         @(negedge clk);
         if (b0.tw_valid) beats++;
      end
      chk("mr_pre_beats", beats, 3);
      b0.tw_ready = 1'b0;
      @(negedge clk);
      chk("mr_stalled_valid", b0.tw_valid, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mr_valid", b0.tw_valid, 0);
      chk("mr_busy", b0.busy, 0);
      chk("mr_done", b0.done, 0);
      rst_n = 1'b1;
      dones = 0;
      repeat (6) begin
         @(negedge clk);
         if (b0.done) dones++;
      end
      chk("mr_no_done", dones, 0);
      b0.tw_ready = 1'b1;
      b0.start = 1'b1;
      @(negedge clk);
      b0.start = 1'b0;
      beats = 0; dones = 0;
      for (c = 0; c < 40 && dones == 0; c++) begin
         @(negedge clk);
         if (b0.done) dones++;
         if (b0.tw_valid) begin
            chk("mr_data", b0.tw_data, rom_tbl[beats % 4]);
            chk("mr_last", b0.tw_last, (beats == 7));
            beats++;
         end
      end
      chk("mr_beats", beats, 8);
      chk("mr_done_after", dones, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/twiddle_fetch_ctrl.md
Name: twiddle_fetch_ctrl

Overview:
- Read-side sequencer for one radix-2 FFT stage's twiddle ROM.
- Generates the per-butterfly ROM address sequence for a frame and absorbs the ROM's 1-cycle registered read latency.
- Delivers twiddle words to the butterfly datapath over a valid/ready stream with a frame-last marker.
- Sits between the stage's distributed twiddle ROM (free-running, no enable) and the butterfly unit.

Parameters:
- ADDR_W, 2, ROM address width; the ROM holds 2^ADDR_W twiddles.
- DATA_W, 28, twiddle word width; passed through unmodified.
- FRAME_LEN, 8, butterflies per frame, in the range 1..65535.
- STRIDE_LOG2, 0, each ROM address is repeated 2^STRIDE_LOG2 consecutive butterflies.
- FIFO_DEPTH, 4, output buffer entries; power of 2, at least 4.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  frame start request; sampled only in IDLE.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse after the final beat is accepted.
- rom_addr  out  ADDR_W  address to the twiddle ROM.
- rom_data  in  DATA_W  ROM registered output, valid 1 cycle after rom_addr.
- tw_data  out  DATA_W  twiddle to the butterfly.
- tw_valid  out  1  tw_data valid.
- tw_ready  in  1  butterfly accepts the beat.
- tw_last  out  1  marks the final beat of the frame; qualified by tw_valid.

Behaviour:
- Reset (rst_n=0 at an edge): the following outputs go to 0: busy, done, rom_addr, tw_valid, tw_last, tw_data. FIFO is emptied, in-flight tracking cleared, butterfly counter reset to 0, state goes to IDLE.
- Reset mid-frame aborts the frame with no done pulse.
- State IDLE:
  - start=1 → RUN, counter b=0.
  - start is ignored in RUN and DRAIN.
- State RUN:
  - An issue happens on a cycle when credit > 0, where credit = FIFO_DEPTH − fifo_count − inflight.
  - On an issue, rom_addr takes (b >> STRIDE_LOG2) mod 2^ADDR_W on the next edge, and b increments.
  - When b = FRAME_LEN−1 is issued → DRAIN.
  - rom_addr holds its last value when not issuing.
- Read pipeline:
  - rom_addr is visible in cycle n; rom_data is valid in cycle n+1; the FIFO captures it at the end of cycle n+1.
  - inflight (0..2) counts issued addresses not yet captured. Each capture carries its beat's last flag (b = FRAME_LEN−1).
- State DRAIN: when the last-flagged beat handshakes (tw_valid & tw_ready) → IDLE; done=1 for the following cycle.
- start arriving during the done cycle is accepted, because the state is already IDLE.
- Latency: start sampled at edge E0 → rom_addr updated at E1 → ROM output at E2 → tw_valid high after E3.
- Throughput: with tw_ready held high, one beat per cycle sustained.
- Handshake rules:
  - A beat transfers on tw_valid & tw_ready.
  - While tw_valid=1 and tw_ready=0, tw_data and tw_last stay stable.
  - tw_valid does not drop without a transfer.
  - tw_valid is independent of tw_ready (no combinational path ready→valid).
- FIFO:
  - Simultaneous push and pop at full or empty is legal.
  - Count stays consistent.
  - The credit rule guarantees no overflow; pushing while full is a design error (assertion).
  - With an empty FIFO, tw_valid=0 and tw_data/tw_last are don't-care.
- FRAME_LEN=1: a single beat with tw_last=1; RUN lasts one issue cycle.
- Address wrap: the address wraps modulo 2^ADDR_W when FRAME_LEN >> STRIDE_LOG2 exceeds 2^ADDR_W.

Test Plan:
- Reset values:
  - Stimulus: hold rst_n=0 for 3 cycles with start=1.
  - Required: busy, tw_valid, done, rom_addr all 0; no issue.
- Full throughput:
  - Stimulus: defaults; ROM model {0:0x6710886, 1:0x4745096, 2:0x0004096, 3:0x2209902}; tw_ready=1; start pulse.
  - Required: rom_addr sequence 0,1,2,3,0,1,2,3 on consecutive cycles.
  - Required: tw_valid first high 3 cycles after start, then 8 contiguous beats with matching data; tw_last only on beat 8; done pulses once the cycle after beat 8.
- Stride:
  - Stimulus: STRIDE_LOG2=1, FRAME_LEN=8.
  - Required: beats carry twiddles for addresses 0,0,1,1,2,2,3,3.
- Backpressure:
  - Stimulus: tw_ready pseudo-random at 30% duty, 64-beat frame.
  - Required: all 64 beats delivered in order, with no loss or duplication; data stable while stalled; fifo_count never exceeds 4.
- Start while busy:
  - Stimulus: pulse start mid-frame, then again exactly in the done cycle.
  - Required: the mid-frame pulse is ignored (exactly 8 beats delivered).
  - Required: the done-cycle pulse launches a second frame.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 after beat 3 with tw_ready=0, then release.
  - Required: tw_valid=0 next cycle; no done pulse; next start delivers a full, correct frame starting at address 0.
